// File: rtl/lcd_cmd_seq.sv
// Command sequencer feeding the LCD controller from a command ROM script.
// Optional feature: define LCD_SEQ_REPEAT_EN to honour the per-entry repeat count in CROM bits [7:4].
module lcd_cmd_seq #(
    parameter int unsigned AW = 6,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          CROM_rd,
    output logic [AW-1:0] CROM_A,
    input  logic [CW-1:0] CROM_Q,
    output logic [3:0]    cmd,
    output logic          cmd_valid,
    input  logic          busy,
    input  logic          done,
    output logic          seq_done,
    output logic [7:0]    issued_cnt
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] ISSUE  = 3'd3;
    localparam logic [2:0] GUARD  = 3'd4;
    localparam logic [2:0] FINISH = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
    localparam logic [3:0]    CMD_WRITE = 4'd0;

    logic [2:0]    state_q, state_d;
    logic          crom_rd_q, crom_rd_d;
    logic [AW-1:0] crom_a_q, crom_a_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          seq_done_q, seq_done_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [3:0]    cur_cmd_q, cur_cmd_d;
    logic [3:0]    rep_left;

    logic is_write;
    logic at_last;
    logic cnt_sat;

    assign is_write = (cur_cmd_q == CMD_WRITE);
    assign at_last  = (crom_a_q == LAST_ADDR);
    assign cnt_sat  = (cnt_q == 8'hFF);

`ifdef LCD_SEQ_REPEAT_EN
    logic [3:0] rep_left_q, rep_left_d;

    // A Write entry is issued once whatever its repeat field says.
    always_comb begin
        rep_left_d = rep_left_q;
        if (state_q == LOAD) begin
            rep_left_d = (CROM_Q[3:0] == CMD_WRITE) ? 4'd0 : CROM_Q[7:4];
        end else if ((state_q == GUARD) && !is_write && (rep_left_q != 4'd0)) begin
            rep_left_d = rep_left_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_left_q <= 4'd0;
        end else begin
            rep_left_q <= rep_left_d;
        end
    end

    assign rep_left = rep_left_q;
`else
    logic unused_crom_hi;

    assign unused_crom_hi = ^CROM_Q[CW-1:4];
    assign rep_left       = 4'd0;
`endif

    always_comb begin
        state_d     = state_q;
        crom_rd_d   = 1'b0;
        crom_a_d    = crom_a_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        seq_done_d  = seq_done_q;
        cnt_d       = cnt_q;
        cur_cmd_d   = cur_cmd_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    crom_rd_d = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                cur_cmd_d = CROM_Q[3:0];
                state_d   = ISSUE;
            end
            ISSUE: begin
                if (!busy) begin
                    cmd_valid_d = 1'b1;
                    cmd_d       = cur_cmd_q;
                    if (!cnt_sat) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    state_d = GUARD;
                end
            end
            GUARD: begin
                // busy is deliberately ignored here so the controller can raise it.
                if (is_write) begin
                    state_d = FINISH;
                end else if (rep_left != 4'd0) begin
                    state_d = ISSUE;
                end else if (at_last) begin
                    cur_cmd_d = CMD_WRITE;
                    state_d   = ISSUE;
                end else begin
                    crom_a_d  = crom_a_q + 1'b1;
                    crom_rd_d = 1'b1;
                    state_d   = FETCH;
                end
            end
            FINISH: begin
                if (done) begin
                    seq_done_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            crom_rd_q   <= 1'b0;
            crom_a_q    <= '0;
            cmd_q       <= 4'd0;
            cmd_valid_q <= 1'b0;
            seq_done_q  <= 1'b0;
            cnt_q       <= 8'd0;
            cur_cmd_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            crom_rd_q   <= crom_rd_d;
            crom_a_q    <= crom_a_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            seq_done_q  <= seq_done_d;
            cnt_q       <= cnt_d;
            cur_cmd_q   <= cur_cmd_d;
        end
    end

    assign CROM_rd    = crom_rd_q;
    assign CROM_A     = crom_a_q;
    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign seq_done   = seq_done_q;
    assign issued_cnt = cnt_q;

    a_valid_single: assert property (@(posedge clk) disable iff (reset)
        cmd_valid |=> !cmd_valid);
    a_done_sticky: assert property (@(posedge clk) disable iff (reset)
        seq_done |=> seq_done);

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq: table of ROM scripts with expected pulse traces,
// plus hand-written sequences for ROM end, saturation, mid-sequence reset and ignored inputs.
module tb_lcd_cmd_seq;

    localparam int AW = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy = 1'b0;
    logic          done = 1'b0;
    logic          CROM_rd;
    logic [AW-1:0] CROM_A;
    logic [CW-1:0] CROM_Q = '0;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic          seq_done;
    logic [7:0]    issued_cnt;

    lcd_cmd_seq #(.AW(AW), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .CROM_rd    (CROM_rd),
        .CROM_A     (CROM_A),
        .CROM_Q     (CROM_Q),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .seq_done   (seq_done),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [64];

    always @(posedge clk) begin
        if (CROM_rd) CROM_Q <= rom[CROM_A];
    end

    typedef struct {
        logic [3:0][7:0] rom_b;
        bit              busy_hold;
        int              n_exp;
        logic [4:0][3:0] exp_cmd;
        logic [4:0][7:0] exp_cyc;
        logic [7:0]      exp_cnt;
    } vec_t;

    vec_t vecs [5];

    int         n_checks = 0;
    int         n_errs = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         consec_err = 0;
    int         busy_viol = 0;
    int         bcnt = 0;
    bit         busy_hold = 1'b0;
    bit         write_seen = 1'b0;
    bit         prev_valid = 1'b0;
    logic       busy_at_edge = 1'b0;
    logic [3:0] log_cmd [$];
    int         log_cyc [$];

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        busy_at_edge <= busy;
    end

    // Pulse logger and busy model: busy high for 10 cycles after each cmd_valid.
    always @(negedge clk) begin
        if (cmd_valid) begin
            log_cmd.push_back(cmd);
            log_cyc.push_back(cyc - start_cyc);
            if (cmd == 4'd0) write_seen = 1'b1;
            if (prev_valid) consec_err++;
            if (busy_at_edge) busy_viol++;
        end
        prev_valid = cmd_valid;
        if (!busy_hold) begin
            busy = 1'b0;
            bcnt = 0;
        end else if (cmd_valid) begin
            busy = 1'b1;
            bcnt = 10;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) busy = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] q_cmd(input int i);
        if (i < log_cmd.size()) return 32'(log_cmd[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] q_cyc(input int i);
        if (i < log_cyc.size()) return 32'(log_cyc[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic set_vec(input int i, input logic [7:0] r0, input logic [7:0] r1,
                           input logic [7:0] r2, input logic [7:0] r3, input bit bh,
                           input int n, input logic [3:0] c0, input logic [3:0] c1,
                           input logic [3:0] c2, input logic [3:0] c3, input logic [3:0] c4,
                           input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
                           input logic [7:0] t3, input logic [7:0] t4, input logic [7:0] cnt);
        vecs[i].rom_b[0]   = r0;
        vecs[i].rom_b[1]   = r1;
        vecs[i].rom_b[2]   = r2;
        vecs[i].rom_b[3]   = r3;
        vecs[i].busy_hold  = bh;
        vecs[i].n_exp      = n;
        vecs[i].exp_cmd[0] = c0;
        vecs[i].exp_cmd[1] = c1;
        vecs[i].exp_cmd[2] = c2;
        vecs[i].exp_cmd[3] = c3;
        vecs[i].exp_cmd[4] = c4;
        vecs[i].exp_cyc[0] = t0;
        vecs[i].exp_cyc[1] = t1;
        vecs[i].exp_cyc[2] = t2;
        vecs[i].exp_cyc[3] = t3;
        vecs[i].exp_cyc[4] = t4;
        vecs[i].exp_cnt    = cnt;
    endtask

    task automatic clear_log();
        log_cmd.delete();
        log_cyc.delete();
        write_seen = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        busy_hold = 1'b0;
        clear_log();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_rom(input logic [3:0][7:0] b);
        for (int a = 0; a < 64; a++) rom[a] = 8'h00;
        for (int a = 0; a < 4; a++) rom[a] = b[a];
    endtask

    // Ends on the negedge right after the edge that sampled start.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_write(input string name, input int limit);
        for (int c = 0; c < limit && !write_seen; c++) begin
            @(negedge clk);
            #1;
        end
        check({name, "_write_issued"}, 32'(write_seen), 32'd1);
    endtask

    // done sampled 5 cycles after the Write strobe; seq_done visible one cycle later.
    task automatic finish_done(input string name);
        repeat (4) @(negedge clk);
        done = 1'b1;
        check({name, "_seq_done_before"}, 32'(seq_done), 32'd0);
        @(negedge clk);
        done = 1'b0;
        #1;
        check({name, "_seq_done_after"}, 32'(seq_done), 32'd1);
        check({name, "_cmd_held"}, 32'(cmd), 32'd0);
    endtask

    task automatic run_vec(input int vi, input bit rst_first);
        string nm;
        nm = $sformatf("vec%0d", vi);
        if (rst_first) do_reset();
        else clear_log();
        load_rom(vecs[vi].rom_b);
        busy_hold = vecs[vi].busy_hold;
        do_start();
        wait_write(nm, 200);
        check({nm, "_npulses"}, 32'(log_cmd.size()), 32'(vecs[vi].n_exp));
        for (int i = 0; i < vecs[vi].n_exp; i++) begin
            check($sformatf("%s_cmd%0d", nm, i), q_cmd(i), 32'(vecs[vi].exp_cmd[i]));
            check($sformatf("%s_cyc%0d", nm, i), q_cyc(i), 32'(vecs[vi].exp_cyc[i]));
        end
        check({nm, "_issued_cnt"}, 32'(issued_cnt), 32'(vecs[vi].exp_cnt));
        finish_done(nm);
    endtask

    initial begin
        //          rom0   rom1   rom2   rom3   busy n  cmds                    cycles          cnt
        set_vec(0, 8'h01, 8'h02, 8'h00, 8'h00, 0, 3, 4'd1, 4'd2, 4'd0, 0, 0, 3, 7, 11, 0, 0, 3);
        set_vec(1, 8'h05, 8'h00, 8'h00, 8'h00, 1, 2, 4'd5, 4'd0, 0, 0, 0, 3, 14, 0, 0, 0, 2);
`ifdef LCD_SEQ_REPEAT_EN
        set_vec(2, 8'h33, 8'h00, 8'h00, 8'h00, 0, 5, 4'd3, 4'd3, 4'd3, 4'd3, 4'd0,
                3, 5, 7, 9, 13, 5);
`else
        set_vec(2, 8'h33, 8'h00, 8'h00, 8'h00, 0, 2, 4'd3, 4'd0, 0, 0, 0, 3, 7, 0, 0, 0, 2);
`endif
        set_vec(3, 8'h04, 8'hF0, 8'h00, 8'h00, 0, 2, 4'd4, 4'd0, 0, 0, 0, 3, 7, 0, 0, 0, 2);
        set_vec(4, 8'h0A, 8'h07, 8'h0F, 8'h00, 0, 4, 4'd10, 4'd7, 4'd15, 4'd0, 0,
                3, 7, 11, 15, 0, 4);

        // Reset state
        do_reset();
        #1;
        check("rst_crom_rd", 32'(CROM_rd), 32'd0);
        check("rst_crom_a", 32'(CROM_A), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_seq_done", 32'(seq_done), 32'd0);
        check("rst_issued_cnt", 32'(issued_cnt), 32'd0);

        for (int v = 0; v < 5; v++) run_vec(v, 1'b1);

        // Full ROM with no Write: forced Write after address 63
        do_reset();
        for (int a = 0; a < 64; a++) rom[a] = 8'h01;
        do_start();
        wait_write("romend", 400);
        check("romend_npulses", 32'(log_cmd.size()), 32'd65);
        check("romend_cmd63", q_cmd(63), 32'd1);
        check("romend_cyc63", q_cyc(63), 32'd255);
        check("romend_cmd64", q_cmd(64), 32'd0);
        check("romend_cyc64", q_cyc(64), 32'd257);
        check("romend_addr", 32'(CROM_A), 32'd63);
        check("romend_issued_cnt", 32'(issued_cnt), 32'd65);
        finish_done("romend");
        check("romend_addr_final", 32'(CROM_A), 32'd63);

`ifdef LCD_SEQ_REPEAT_EN
        // 64 x 16 + 1 strobes: issued_cnt must stick at 255
        do_reset();
        for (int a = 0; a < 64; a++) rom[a] = 8'hF1;
        do_start();
        wait_write("sat", 5000);
        check("sat_npulses", 32'(log_cmd.size()), 32'd1025);
        check("sat_issued_cnt", 32'(issued_cnt), 32'd255);
        finish_done("sat");
`endif

        // Asynchronous reset while the second command sits in ISSUE
        do_reset();
        load_rom(vecs[0].rom_b);
        do_start();
        for (int c = 0; c < 50 && log_cmd.size() < 1; c++) begin
            @(negedge clk);
            #1;
        end
        check("midrst_pre_cmd", 32'(cmd), 32'd1);
        check("midrst_pre_cnt", 32'(issued_cnt), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("midrst_cmd", 32'(cmd), 32'd0);
        check("midrst_crom_rd", 32'(CROM_rd), 32'd0);
        check("midrst_crom_a", 32'(CROM_A), 32'd0);
        check("midrst_issued_cnt", 32'(issued_cnt), 32'd0);
        check("midrst_seq_done", 32'(seq_done), 32'd0);
        repeat (2) @(negedge clk);
        check("midrst_no_pulse", 32'(log_cmd.size()), 32'd1);
        reset = 1'b0;
        run_vec(0, 1'b0);

        // done while in ISSUE and start while in FINISH/DONE are ignored
        do_reset();
        for (int a = 0; a < 64; a++) rom[a] = 8'h00;
        rom[0] = 8'h01;
        do_start();
        repeat (2) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        wait_write("ign", 50);
        check("ign_npulses", 32'(log_cmd.size()), 32'd2);
        check("ign_cyc1", q_cyc(1), 32'd7);
        check("ign_seq_done_early", 32'(seq_done), 32'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("ign_finish_seq_done", 32'(seq_done), 32'd0);
        check("ign_finish_no_pulse", 32'(log_cmd.size()), 32'd2);
        check("ign_finish_no_rd", 32'(CROM_rd), 32'd0);
        finish_done("ign");
        do_start();
        repeat (6) @(negedge clk);
        #1;
        check("ign_done_no_pulse", 32'(log_cmd.size()), 32'd2);
        check("ign_done_sticky", 32'(seq_done), 32'd1);

        check("single_cycle_strobe", 32'(consec_err), 32'd0);
        check("no_strobe_while_busy", 32'(busy_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
